// File: rtl/pulse_stretch_if.sv
// Event/level bundle between a pulse source and the pulse stretcher.
// The master drives the trigger and its length; the slave returns the stretched level and status.
interface pulse_stretch_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pulse_in;
  logic [CNT_W-1:0] len;
  logic             level;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output pulse_in,
    output len,
    input  level,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  pulse_in,
    input  len,
    output level,
    output busy,
    output done,
    output overrun
  );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into a level held for len cycles, with a guaranteed low gap
// between stretches and a one-deep pending slot for events that arrive while busy.
module pulse_stretch #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GAP       = 2,
  parameter bit          RETRIGGER = 1'b0
) (
  input  logic            clk_d,
  input  logic            rst_n,
  pulse_stretch_if.slave  bus
);

  if (GAP == 0 || GAP > 255) begin : g_gap_check
    $error("pulse_stretch: GAP must be in 1..255");
  end

  localparam logic [7:0] GapLast = 8'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StActive, StGaps} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_len_q, pend_len_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             trig;

  // A zero-length request is not an event at all.
  assign trig = bus.pulse_in && (bus.len != '0);

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          cnt_d   = bus.len - CNT_W'(1);
          state_d = StActive;
        end
      end
      StActive: begin
        if (trig && RETRIGGER) begin
          // Reload wins over the exit so the level never drops.
          cnt_d = bus.len - CNT_W'(1);
        end else begin
          if (trig) begin
            pend_d     = 1'b1;
            pend_len_d = bus.len;
          end
          if (cnt_q == '0) begin
            gcnt_d  = GapLast;
            state_d = StGaps;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StGaps: begin
        if (gcnt_q == '0) begin
          if (trig) begin
            cnt_d   = bus.len - CNT_W'(1);
            pend_d  = 1'b0;
            state_d = StActive;
          end else if (pend_q) begin
            cnt_d   = pend_len_q - CNT_W'(1);
            pend_d  = 1'b0;
            state_d = StActive;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gcnt_d = gcnt_q - 8'd1;
          if (trig) begin
            pend_d     = 1'b1;
            pend_len_d = bus.len;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so level and busy rise on the same edge.
  always_comb begin
    level_d   = (state_d == StActive);
    busy_d    = (state_d != StIdle) || pend_d;
    done_d    = (state_q == StActive) && (state_d == StGaps);
    overrun_d = trig && pend_q &&
                ((state_q == StGaps) || ((state_q == StActive) && !RETRIGGER));
  end

  assign bus.level   = level_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: one queueing instance and one retriggering instance.
// Outputs are compared as {level, busy, done, overrun} one time step after each rising edge.
module tb_pulse_stretch;

  logic clk_d = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_d = ~clk_d;

  pulse_stretch_if #(.CNT_W(8)) b0 ();
  pulse_stretch_if #(.CNT_W(8)) b1 ();

  pulse_stretch #(.CNT_W(8), .GAP(2), .RETRIGGER(1'b0)) u_queue (
    .clk_d (clk_d),
    .rst_n (rst_n),
    .bus   (b0)
  );

  pulse_stretch #(.CNT_W(8), .GAP(2), .RETRIGGER(1'b1)) u_retrig (
    .clk_d (clk_d),
    .rst_n (rst_n),
    .bus   (b1)
  );

  task automatic chk(input bit sel, input logic [3:0] exp, input string tag);
    logic [3:0] obs;
    obs = sel ? {b1.level, b1.busy, b1.done, b1.overrun}
              : {b0.level, b0.busy, b0.done, b0.overrun};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got lvl/bsy/dn/ovr=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus into the selected instance, clock it, then check.
  task automatic cyc(input bit sel, input bit p, input logic [7:0] l, input logic [3:0] exp,
                     input string tag);
    if (sel) begin
      b1.pulse_in = p;
      b1.len      = l;
    end else begin
      b0.pulse_in = p;
      b0.len      = l;
    end
    @(posedge clk_d);
    #1;
    chk(sel, exp, tag);
  endtask

  initial begin
    b0.pulse_in = 1'b0;
    b0.len      = 8'd0;
    b1.pulse_in = 1'b0;
    b1.len      = 8'd0;
    repeat (2) @(posedge clk_d);
    #1;
    chk(1'b0, 4'b0000, "reset q");
    chk(1'b1, 4'b0000, "reset r");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "idle");

    // Single len=5 stretch: 5 high, done on first low, busy 7 cycles total.
    cyc(1'b0, 1'b1, 8'd5, 4'b1100, "t1 c0");
    for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0, 8'd0, 4'b1100, $sformatf("t1 c%0d", i));
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t1 done");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t1 gap");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "t1 idle");

    // Zero-length triggers are ignored.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'd0, 4'b0000, $sformatf("t2 c%0d", i));

    // Queued request: 4 high, 2 low, 3 high.
    cyc(1'b0, 1'b1, 8'd4, 4'b1100, "t3 c0");
    cyc(1'b0, 1'b0, 8'd0, 4'b1100, "t3 c1");
    cyc(1'b0, 1'b1, 8'd3, 4'b1100, "t3 c2");
    cyc(1'b0, 1'b0, 8'd0, 4'b1100, "t3 c3");
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t3 done1");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t3 gap");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0, 4'b1100, $sformatf("t3 h%0d", i));
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t3 done2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t3 gap2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "t3 idle");

    // Overwritten pending: overrun on 3rd and 4th triggers, second stretch is 6.
    cyc(1'b0, 1'b1, 8'd8, 4'b1100, "t4 c0");
    cyc(1'b0, 1'b1, 8'd2, 4'b1100, "t4 c1");
    cyc(1'b0, 1'b1, 8'd3, 4'b1101, "t4 ovr1");
    cyc(1'b0, 1'b1, 8'd6, 4'b1101, "t4 ovr2");
    for (int i = 4; i < 8; i++) cyc(1'b0, 1'b0, 8'd0, 4'b1100, $sformatf("t4 c%0d", i));
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t4 done1");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t4 gap");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'd0, 4'b1100, $sformatf("t4 h%0d", i));
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t4 done2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t4 gap2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "t4 idle");

    // Retrigger reload: 7 continuous high cycles, a single done.
    cyc(1'b1, 1'b1, 8'd4, 4'b1100, "t5 c0");
    cyc(1'b1, 1'b0, 8'd0, 4'b1100, "t5 c1");
    cyc(1'b1, 1'b0, 8'd0, 4'b1100, "t5 c2");
    cyc(1'b1, 1'b1, 8'd4, 4'b1100, "t5 c3");
    for (int i = 4; i < 7; i++) cyc(1'b1, 1'b0, 8'd0, 4'b1100, $sformatf("t5 c%0d", i));
    cyc(1'b1, 1'b0, 8'd0, 4'b0110, "t5 done");
    cyc(1'b1, 1'b0, 8'd0, 4'b0100, "t5 gap");
    cyc(1'b1, 1'b0, 8'd0, 4'b0000, "t5 idle");

    // Trigger on the last gap cycle beats the stored request and flags overrun.
    cyc(1'b0, 1'b1, 8'd3, 4'b1100, "t6 c0");
    cyc(1'b0, 1'b1, 8'd2, 4'b1100, "t6 c1");
    cyc(1'b0, 1'b0, 8'd0, 4'b1100, "t6 c2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t6 done1");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t6 gap");
    cyc(1'b0, 1'b1, 8'd7, 4'b1101, "t6 ovr");
    for (int i = 1; i < 7; i++) cyc(1'b0, 1'b0, 8'd0, 4'b1100, $sformatf("t6 h%0d", i));
    cyc(1'b0, 1'b0, 8'd0, 4'b0110, "t6 done2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0100, "t6 gap2");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "t6 idle");

    // Asynchronous reset mid-ACTIVE with a pending request.
    cyc(1'b0, 1'b1, 8'd5, 4'b1100, "t7 c0");
    cyc(1'b0, 1'b1, 8'd3, 4'b1100, "t7 c1");
    b0.pulse_in = 1'b0;
    b0.len      = 8'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk(1'b0, 4'b0000, "t7 async");
    @(posedge clk_d);
    #1;
    chk(1'b0, 4'b0000, "t7 held");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'd0, 4'b0000, $sformatf("t7 post%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Converts single-cycle event pulses (e.g. a hit pulse from the push-button edge detector) back into a level held high for a programmable number of clk_d cycles.
- Drives mole/hit LEDs and other level-sensitive consumers.
- Guarantees a minimum low gap between successive stretched levels, so a downstream edge detector always sees distinct rising edges.
- Holds one pending request, captured while busy, so back-to-back events are not lost.

Parameters:
- CNT_W, 8: width of the len input and of the internal duration counter.
- GAP, 2: minimum number of low cycles between two stretched levels. Legal range 1..255; elaboration error if 0.
- RETRIGGER, 0: when 1, a pulse during ACTIVE reloads the duration counter. When 0, it is queued as pending.

Ports:
- clk_d, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- pulse_in, input, 1: event strobe, sampled every rising edge of clk_d. Multi-cycle highs count as one trigger per cycle.
- len, input, CNT_W: requested high duration in cycles, sampled together with pulse_in.
- level, output, 1: stretched output, registered.
- busy, output, 1: registered. High when state is not IDLE or pending is set.
- done, output, 1: one-cycle registered strobe, high in the first cycle after level falls.
- overrun, output, 1: one-cycle registered strobe, high when an existing pending request is overwritten.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - level, busy, done, overrun = 0.
  - cnt, gcnt, pend_len = 0; pend = 0.
  - Reset mid-operation aborts immediately; no done is produced.
- Valid trigger: pulse_in = 1 and len != 0.
  - A trigger with len == 0 is ignored entirely: no state change, no pend, no overrun.
- States: IDLE, ACTIVE, GAPS.
- IDLE:
  - On a valid trigger: cnt <= len - 1, level <= 1, state <= ACTIVE.
  - level rises in the cycle after pulse_in is sampled (latency 1).
- ACTIVE (level = 1):
  - When cnt != 0, cnt decrements each cycle.
  - Valid trigger with RETRIGGER = 1: cnt <= len - 1. This takes priority over the cnt == 0 exit, and level stays high continuously.
  - Valid trigger with RETRIGGER = 0: pend <= 1, pend_len <= len (newest wins). If pend was already 1, overrun pulses high.
  - On cnt == 0 with no retrigger: level <= 0, done <= 1, gcnt <= GAP - 1, state <= GAPS.
  - Without retriggering, level is high for exactly len cycles.
- GAPS (level = 0):
  - gcnt decrements each cycle.
  - A valid trigger sets pend / pend_len, with the same overrun rule as ACTIVE.
  - On gcnt == 0:
    - If a valid trigger is present this cycle, start ACTIVE with cnt <= len - 1. The incoming request beats the stored one; if pend was set, overrun pulses.
    - Else if pend, start ACTIVE with cnt <= pend_len - 1.
    - In both cases: pend <= 0, level <= 1.
    - Otherwise state <= IDLE.
  - level is therefore low for exactly GAP cycles between stretches.
- done and overrun are high for one cycle only and are never asserted together with reset.
- busy is registered from next-state and next-pend, so it rises together with level.
- cnt width is CNT_W. len = 2^CNT_W - 1 gives the maximum high time; no wrap can occur because the counter only decrements and stops at 0.

Test Plan:
- Reset, then pulse_in for 1 cycle with len = 5 -> level high for exactly 5 cycles, starting 1 cycle after the pulse. done is high on the first low cycle. busy is high 5 + 2 cycles (GAP = 2), then low.
- Trigger with len = 0 in IDLE -> level, busy, done, overrun remain 0 for 10 cycles.
- RETRIGGER = 0: len = 4 at t0, then len = 3 at t2 -> level high 4 cycles, low exactly 2, high 3, then IDLE. overrun stays 0. Two done strobes.
- RETRIGGER = 0: three triggers during ACTIVE with len = 2, 3, 6 -> overrun pulses on the 3rd and 4th overall triggers. The second stretch lasts 6 cycles.
- RETRIGGER = 1: len = 4 at t0, len = 4 at t3 -> level high continuously for 7 cycles; one done.
- GAPS final cycle: pend_len = 2 stored, new trigger len = 7 arrives on gcnt == 0 -> next stretch lasts 7 cycles and overrun pulses once. rst_n asserted mid-ACTIVE -> level drops asynchronously, no done strobe, pend cleared.
